// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial, LSB-first subtractor: Diff = A - B - Bin (mod 2^WIDTH).
//   One full-subtractor cell is reused for every bit. The borrow between bits
//   is held in a flop. A Start/Busy/Done handshake runs one operation at a time.
//
// Ports
//   Clk    in   system clock, rising-edge
//   Rst    in   asynchronous, active-high reset
//   Start  in   request pulse, only sampled while idle
//   A      in   [WIDTH] minuend, captured when Start is accepted
//   B      in   [WIDTH] subtrahend, captured when Start is accepted
//   Bin    in   borrow-in, captured when Start is accepted
//   Busy   out  high through the SHIFT and DONE states
//   Done   out  one-cycle pulse; Diff/Bout are updated in this cycle
//   Diff   out  [WIDTH] registered difference, holds the last result
//   Bout   out  registered borrow-out of the MSB, holds the last result
// -----------------------------------------------------------------------------

// Single-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);
    // One extra counter bit so the count never wraps inside an operation.
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             borrow;
    logic             d;
    logic             borrow_next;
    logic [CW-1:0]    cnt;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (d),
        .bout (borrow_next)
    );

    // Result bits enter from the MSB side. After WIDTH shifts the first
    // (LSB) difference bit has reached position 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = d;
        end else begin : g_res_wn
            assign res_next = {d, res_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        borrow <= Bin;
                        res_sh <= '0;
                        cnt    <= '0;
                        Busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= borrow_next;
                    res_sh <= res_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Final bit: publish the result on the DONE-entry edge.
                        Diff  <= res_next;
                        Bout  <= borrow_next;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Start is ignored here; the next one is taken from IDLE.
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed bench for serial_subtractor. It uses WIDTH=8 for the handshake,
//   timing and reset vectors, and a WIDTH=4 instance for the full operand sweep.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;
    logic       Clk;
    logic       Rst;
    logic       Start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       Busy;
    logic       Done;
    logic [7:0] Diff;
    logic       Bout;

    logic       Start4;
    logic [3:0] A4;
    logic [3:0] B4;
    logic       Bin4;
    logic       Busy4;
    logic       Done4;
    logic [3:0] Diff4;
    logic       Bout4;

    int n_chk = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .A(A), .B(B), .Bin(Bin),
        .Busy(Busy), .Done(Done), .Diff(Diff), .Bout(Bout)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .Start(Start4), .A(A4), .B(B4), .Bin(Bin4),
        .Busy(Busy4), .Done(Done4), .Diff(Diff4), .Bout(Bout4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Run one WIDTH=8 operation from IDLE and check latency, busy length,
    // result and the one-cycle Done pulse. The task returns in IDLE.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tbin, input logic [7:0] ed, input logic eb);
        int lat;
        int bcyc;
        Start = 1'b1; A = ta; B = tb_v; Bin = tbin;
        step();                       // accepting edge
        Start = 1'b0;
        lat = 0; bcyc = 0;
        for (int i = 0; i < 30; i++) begin
            if (Busy) bcyc++;
            if (Done) break;
            step();
            lat++;
        end
        chk({tag, "_lat"},  lat, 8);
        chk({tag, "_busy"}, bcyc, 9);
        chk({tag, "_diff"}, Diff, ed);
        chk({tag, "_bout"}, Bout, eb);
        step();
        chk({tag, "_done_pulse"}, Done, 0);
        chk({tag, "_idle_busy"},  Busy, 0);
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                       input logic [3:0] ed, input logic eb);
        int lat;
        Start4 = 1'b1; A4 = ta; B4 = tb_v; Bin4 = tbin;
        step();
        Start4 = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (Done4) break;
            step();
            lat++;
        end
        chk("w4_lat", lat, 4);
        if (Diff4 !== ed || Bout4 !== eb)
            $display("  case a=%0h b=%0h bin=%0b", ta, tb_v, tbin);
        chk("w4_diff", Diff4, ed);
        chk("w4_bout", Bout4, eb);
        step();
    endtask

    initial begin
        int d1, d2;
        logic [7:0] r1, r2;
        logic       rb2;
        Rst = 1'b1; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        Start4 = 1'b0; A4 = '0; B4 = '0; Bin4 = 1'b0;
        step(); step();
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_diff", Diff, 0);
        chk("rst_bout", Bout, 0);
        Rst = 1'b0;
        step();

        // Basic vectors.
        op8("v05m03",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        op8("v03m05",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        op8("v00m00b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        op8("vFFm00",   8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);

        // Inputs scrambled during SHIFT; Diff holds the prior 0xFF until DONE.
        chk("hold_idle", Diff, 8'hFF);
        Start = 1'b1; A = 8'h0A; B = 8'h0A; Bin = 1'b0;
        step();
        Start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("hold_shift_diff", Diff, 8'hFF);
            chk("hold_shift_done", Done, 0);
            A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
            step();
        end
        chk("scr_done", Done, 1);
        chk("scr_diff", Diff, 8'h00);
        chk("scr_bout", Bout, 0);
        step();

        // Start held high: Start is ignored in SHIFT/DONE, and re-accepted on the first IDLE cycle.
        Start = 1'b1; A = 8'h10; B = 8'h01; Bin = 1'b0;
        step();
        A = 8'h20; B = 8'h03;
        d1 = -1; d2 = -1; r1 = '0; r2 = '0; rb2 = 1'bx;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (Done) begin
                if (d1 < 0) begin
                    d1 = cyc; r1 = Diff;
                end else begin
                    d2 = cyc; r2 = Diff; rb2 = Bout;
                    break;
                end
            end
            step();
        end
        Start = 1'b0;
        chk("held_first_lat", d1, 8);
        chk("held_spacing",   d2 - d1, 10);
        chk("held_r1",        r1, 8'h0F);
        chk("held_r2",        r2, 8'h1D);
        chk("held_b2",        rb2, 0);
        step();
        step();
        chk("held_no_third", Busy, 0);

        // Asynchronous reset partway through SHIFT, between clock edges.
        Start = 1'b1; A = 8'h33; B = 8'h11; Bin = 1'b1;
        step();
        Start = 1'b0;
        step(); step();
        #2;
        Rst = 1'b1;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_done", Done, 0);
        chk("arst_diff", Diff, 0);
        chk("arst_bout", Bout, 0);
        Start = 1'b1;
        step();
        chk("arst_start_ignored", Busy, 0);
        Start = 1'b0;
        Rst = 1'b0;
        step();
        op8("post_rst", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

        // Full sweep on the 4-bit instance against the arithmetic model.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++) begin
                    int diff_m;
                    diff_m = (a - b - bi + 32) % 16;
                    op4(4'(a), 4'(b), 1'(bi), 4'(diff_m), (a < b + bi) ? 1'b1 : 1'b0);
                end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
